// File: rtl/conv10_sched.sv
// conv10_sched: sequences conv10_1 then conv10_2 on the shared MAC array.
// Optional perf counters: define CONV10_SCHED_PERF_EN.
module conv10_sched #(
  parameter int WOUT    = 8,
  parameter int CHIN    = 736,
  parameter int TIMEOUT = 2*WOUT*WOUT*(CHIN+1)+64,
  parameter int AW      = $clog2(WOUT*WOUT)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          ifm_1_valid,
  input  logic          ifm_2_valid,
  input  logic          conv10_1_sample,
  input  logic          conv10_1_finish,
  input  logic          conv10_2_finish,
  output logic          conv10_1_en_o,
  output logic          conv10_2_en_o,
  output logic          ram_feedback_1_o,
  output logic          ram_feedback_2_o,
  output logic          ofm_wr_en,
  output logic          ofm_wr_sel,
  output logic [AW-1:0] ofm_wr_addr,
  output logic          busy,
  output logic          done,
  output logic          err
`ifdef CONV10_SCHED_PERF_EN
  ,
  output logic [31:0]   perf_run1_cyc,
  output logic [31:0]   perf_run2_cyc,
  output logic [31:0]   perf_stall_cyc
`endif
);

  localparam int NPIX = WOUT*WOUT;
  localparam int PW   = $clog2(NPIX+1);
  localparam int WW   = $clog2(TIMEOUT+1);

  typedef enum logic [2:0] {
    IDLE, WAIT1, RUN1, ACK1,
    WAIT2, RUN2, ACK2, FIN
  } state_t;

  state_t        state, nxt;
  logic [PW-1:0] pix_cnt;
  logic [WW-1:0] wdog;
  logic          run, fin_in, tmo, full, ack;

  assign run    = (state == RUN1) || (state == RUN2);
  assign ack    = (state == ACK1) || (state == ACK2);
  assign fin_in = (state == RUN1) ? conv10_1_finish
                                  : conv10_2_finish;
  assign tmo    = run && (wdog == WW'(TIMEOUT-1));
  assign full   = (pix_cnt == PW'(NPIX));

  // A finish level wins over a coincident watchdog expiry.
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:  if (start) nxt = WAIT1;
      WAIT1: if (ifm_1_valid) nxt = RUN1;
      RUN1:  if (conv10_1_finish) nxt = ACK1;
             else if (tmo) nxt = FIN;
      ACK1:  nxt = WAIT2;
      WAIT2: if (ifm_2_valid) nxt = RUN2;
      RUN2:  if (conv10_2_finish) nxt = ACK2;
             else if (tmo) nxt = FIN;
      ACK2:  nxt = FIN;
      FIN:   nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      pix_cnt          <= '0;
      wdog             <= '0;
      conv10_1_en_o    <= 1'b0;
      conv10_2_en_o    <= 1'b0;
      ram_feedback_1_o <= 1'b0;
      ram_feedback_2_o <= 1'b0;
      ofm_wr_en        <= 1'b0;
      ofm_wr_sel       <= 1'b0;
      ofm_wr_addr      <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      err              <= 1'b0;
    end else begin
      state            <= nxt;
      conv10_1_en_o    <= (nxt == RUN1);
      conv10_2_en_o    <= (nxt == RUN2);
      ram_feedback_1_o <= (nxt == ACK1);
      ram_feedback_2_o <= (nxt == ACK2);
      busy             <= (nxt != IDLE);
      done             <= (nxt == FIN);
      ofm_wr_en        <= 1'b0;
      if (state == IDLE && start) begin
        pix_cnt <= '0;
        wdog    <= '0;
      end
      if (run) begin
        wdog <= wdog + WW'(1);
        if (conv10_1_sample) begin
          if (full) begin
            err <= 1'b1;
          end else begin
            ofm_wr_en   <= 1'b1;
            ofm_wr_sel  <= (state == RUN2);
            ofm_wr_addr <= pix_cnt[AW-1:0];
            pix_cnt     <= pix_cnt + PW'(1);
          end
        end
        // wdog is zero only on the first RUN cycle: stale finish.
        if (wdog == '0 && fin_in) err <= 1'b1;
        if (tmo && !fin_in) err <= 1'b1;
      end
      if (ack) begin
        if (!full) err <= 1'b1;
        pix_cnt <= '0;
        wdog    <= '0;
      end
    end
  end

`ifdef CONV10_SCHED_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_run1_cyc  <= '0;
      perf_run2_cyc  <= '0;
      perf_stall_cyc <= '0;
    end else if (state == IDLE && start) begin
      perf_run1_cyc  <= '0;
      perf_run2_cyc  <= '0;
      perf_stall_cyc <= '0;
    end else begin
      if (state == RUN1) perf_run1_cyc <= perf_run1_cyc + 32'd1;
      if (state == RUN2) perf_run2_cyc <= perf_run2_cyc + 32'd1;
      if (state == WAIT1 || state == WAIT2)
        perf_stall_cyc <= perf_stall_cyc + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_conv10_sched.sv
// tb_conv10_sched: random-gap datapath model driving conv10_sched,
// writes scoreboarded against the expected pixel sequence per layer.
module tb_conv10_sched;

  localparam int AW  = 6;
  localparam int NP  = 64;
  localparam int TMO = 1000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic v1 = 1'b0, v2 = 1'b0;
  logic smp = 1'b0, f1 = 1'b0, f2 = 1'b0;
  logic en1, en2, fb1, fb2, wr_en, wr_sel;
  logic [AW-1:0] wr_addr;
  logic busy, done, err;

  int n_chk = 0;
  int n_err = 0;

  logic [6:0] wq[$];
  int n_fb1 = 0, n_fb2 = 0, n_done = 0;
  int n_ovl = 0, n_en1 = 0, n_en2 = 0;

  always #5 clk = ~clk;

  conv10_sched #(.WOUT(8), .CHIN(736), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .ifm_1_valid(v1), .ifm_2_valid(v2),
    .conv10_1_sample(smp),
    .conv10_1_finish(f1), .conv10_2_finish(f2),
    .conv10_1_en_o(en1), .conv10_2_en_o(en2),
    .ram_feedback_1_o(fb1), .ram_feedback_2_o(fb2),
    .ofm_wr_en(wr_en), .ofm_wr_sel(wr_sel),
    .ofm_wr_addr(wr_addr),
    .busy(busy), .done(done), .err(err)
  );

  always @(negedge clk) begin
    if (wr_en) wq.push_back({wr_sel, wr_addr});
    if (fb1) n_fb1++;
    if (fb2) n_fb2++;
    if (done) n_done++;
    if (en1 && en2) n_ovl++;
    if (en1) n_en1++;
    if (en2) n_en2++;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    start = 0; smp = 0; f1 = 0; f2 = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_layer(input int l, input int n, input bit fin);
    int t = 0;
    while (!(l == 1 ? en1 : en2) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check($sformatf("en%0d_up", l), 32'(t < 3000), 1);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 4)) @(negedge clk);
      smp = 1'b1;
      @(negedge clk);
      smp = 1'b0;
    end
    if (fin) begin
      if (l == 1) f1 = 1'b1; else f2 = 1'b1;
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!(l == 1 ? fb1 : fb2) && t < 20);
      check($sformatf("fb%0d_seen", l), 32'(t < 20), 1);
      f1 = 1'b0;
      f2 = 1'b0;
    end
  endtask

  task automatic wait_done();
    int t = 0;
    while (!done && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check("done_seen", 32'(t < 3000), 1);
    @(negedge clk);
    check("busy_low", 32'(busy), 0);
  endtask

  task automatic check_writes(input int base, input int n1,
                              input int n2, input string tag);
    logic [6:0] ex[$];
    for (int i = 0; i < n1 && i < NP; i++) ex.push_back({1'b0, 6'(i)});
    for (int i = 0; i < n2 && i < NP; i++) ex.push_back({1'b1, 6'(i)});
    check({tag, "_nwr"}, 32'(wq.size() - base), 32'(ex.size()));
    for (int i = 0; i < ex.size() && base + i < wq.size(); i++)
      check({tag, "_wr"}, 32'(wq[base+i]), 32'(ex[i]));
  endtask

  task automatic full_pass(input int n1, input int n2,
                           input bit stale, input string tag);
    int wb = wq.size();
    int b1 = n_fb1, b2 = n_fb2, bd = n_done, bo = n_ovl;
    v1 = 1'b1;
    v2 = 1'b1;
    f1 = stale;
    pulse_start();
    run_layer(1, n1, 1'b1);
    run_layer(2, n2, 1'b1);
    wait_done();
    check_writes(wb, n1, n2, tag);
    check({tag, "_fb1"}, 32'(n_fb1 - b1), 1);
    check({tag, "_fb2"}, 32'(n_fb2 - b2), 1);
    check({tag, "_done"}, 32'(n_done - bd), 1);
    check({tag, "_ovl"}, 32'(n_ovl - bo), 0);
    check({tag, "_err"}, 32'(err),
          32'(stale || n1 != NP || n2 != NP));
  endtask

  initial begin
    int wb, b1, bd, be1, be2, hi;
    repeat (2) @(negedge clk);
    check("rst_outs",
          {22'd0, en1, en2, fb1, fb2, wr_en, wr_sel, busy, done, err, 1'b0},
          0);
    check("rst_addr", 32'(wr_addr), 0);
    rst_n = 1'b1;

    full_pass(NP, NP, 1'b0, "nom");
    do_reset();
    full_pass(40, NP, 1'b0, "early");
    do_reset();
    full_pass(NP, 65, 1'b0, "ovr");
    do_reset();
    full_pass(0, NP, 1'b1, "stale");
    do_reset();

    // Stall: conv10_2 input held off 500 cycles after ACK1
    wb = wq.size();
    v1 = 1'b1;
    v2 = 1'b0;
    pulse_start();
    run_layer(1, NP, 1'b1);
    hi = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (en2) hi++;
    end
    check("stall_en2_low", 32'(hi), 0);
    check("stall_busy", 32'(busy), 1);
    v2 = 1'b1;
    @(negedge clk);
    check("stall_en2_rise", 32'(en2), 1);
    run_layer(2, NP, 1'b1);
    wait_done();
    check_writes(wb, NP, NP, "stall");
    check("stall_err", 32'(err), 0);
    do_reset();

    // Timeout: no finish in RUN1
    wb = wq.size();
    b1 = n_fb1; bd = n_done; be1 = n_en1; be2 = n_en2;
    v1 = 1'b1;
    v2 = 1'b1;
    pulse_start();
    run_layer(1, 10, 1'b0);
    wait_done();
    check("tmo_en1_cyc", 32'(n_en1 - be1), TMO);
    check("tmo_en2_cyc", 32'(n_en2 - be2), 0);
    check("tmo_fb1", 32'(n_fb1 - b1), 0);
    check("tmo_done", 32'(n_done - bd), 1);
    check("tmo_err", 32'(err), 1);
    check_writes(wb, 10, 0, "tmo");
    do_reset();

    // Reset mid-RUN2 after 30 writes, then a clean rerun
    wb = wq.size();
    pulse_start();
    run_layer(1, NP, 1'b1);
    run_layer(2, 30, 1'b0);
    @(negedge clk);
    check("mid_en2", 32'(en2), 1);
    check_writes(wb, NP, 30, "mid");
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_outs",
          {22'd0, en1, en2, fb1, fb2, wr_en, wr_sel, busy, done, err, 1'b0},
          0);
    check("mid_rst_addr", 32'(wr_addr), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    full_pass(NP, NP, 1'b0, "rerun");

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
